// File: rtl/audio_mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read master among NUM_REQ requesters, one transaction in flight.
// Optional: define AUDIO_MEM_ARB_PRIO0_EN to give requester 0 (audio fetcher) absolute priority.
module audio_mem_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_araddr,
  input  logic [NUM_REQ-1:0]          s_arvalid,
  output logic [NUM_REQ-1:0]          s_arready,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [NUM_REQ-1:0]          s_rvalid,
  input  logic [NUM_REQ-1:0]          s_rready,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]    grant_nxt, winner;
  logic [NUM_REQ-1:0]  s_arready_nxt, s_rvalid_nxt;
  logic [ADDR_W-1:0]   m_araddr_nxt;
  logic [DATA_W-1:0]   s_rdata_nxt;
  logic                m_arvalid_nxt, m_rready_nxt, busy_nxt;

  // First requesting index at or above ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] pick_rr(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] g;
    logic             found;
    int               k;
    g     = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        g     = IDX_W'(k);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
  endfunction

`ifdef AUDIO_MEM_ARB_PRIO0_EN
  localparam logic [NUM_REQ-1:0] REQ0_MASK = NUM_REQ'(1);

  // Requester 0 pre-empts; the rest rotate among themselves without ever landing on 0.
  always_comb begin
    winner = s_arvalid[0] ? '0 : pick_rr(s_arvalid & ~REQ0_MASK, rr_ptr);
  end
`else
  always_comb begin
    winner = pick_rr(s_arvalid, rr_ptr);
  end
`endif

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_idx;
    s_arready_nxt = '0;
    s_rvalid_nxt  = s_rvalid;
    s_rdata_nxt   = s_rdata;
    m_araddr_nxt  = m_araddr;
    m_arvalid_nxt = m_arvalid;
    m_rready_nxt  = m_rready;
    case (state)
      IDLE: begin
        if (|s_arvalid) begin
          grant_nxt     = winner;
          m_araddr_nxt  = s_araddr[winner*ADDR_W +: ADDR_W];
          s_arready_nxt = NUM_REQ'(1) << winner;
          m_arvalid_nxt = 1'b1;
          state_nxt     = ADDR;
        end
      end
      ADDR: begin
        if (m_arvalid && m_arready) begin
          m_arvalid_nxt = 1'b0;
          m_rready_nxt  = 1'b1;
          state_nxt     = DATA;
        end
      end
      DATA: begin
        if (m_rvalid && m_rready) begin
          s_rdata_nxt  = m_rdata;
          m_rready_nxt = 1'b0;
          s_rvalid_nxt = NUM_REQ'(1) << grant_idx;
          state_nxt    = RESP;
        end
      end
      RESP: begin
        if (s_rready[grant_idx]) begin
          s_rvalid_nxt = '0;
`ifdef AUDIO_MEM_ARB_PRIO0_EN
          if (grant_idx != '0) rr_ptr_nxt = next_ptr(grant_idx);
`else
          rr_ptr_nxt   = next_ptr(grant_idx);
`endif
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Every output comes straight from a flop; a reset drops any in-flight response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      s_arready <= '0;
      s_rvalid  <= '0;
      s_rdata   <= '0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_nxt;
      s_arready <= s_arready_nxt;
      s_rvalid  <= s_rvalid_nxt;
      s_rdata   <= s_rdata_nxt;
      m_araddr  <= m_araddr_nxt;
      m_arvalid <= m_arvalid_nxt;
      m_rready  <= m_rready_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_audio_mem_read_arbiter.sv
// Directed bench for audio_mem_read_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_audio_mem_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      aclk    = 1'b0;
  logic                      aresetn = 1'b1;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ-1:0]        s_arvalid = '0;
  logic [NUM_REQ-1:0]        s_arready;
  logic [DATA_W-1:0]         s_rdata;
  logic [NUM_REQ-1:0]        s_rvalid;
  logic [NUM_REQ-1:0]        s_rready  = '0;
  logic [ADDR_W-1:0]         m_araddr;
  logic                      m_arvalid;
  logic                      m_arready = 1'b0;
  logic [DATA_W-1:0]         m_rdata   = '0;
  logic                      m_rvalid  = 1'b0;
  logic                      m_rready;
  logic [1:0]                grant_idx;
  logic                      busy;

  logic [ADDR_W-1:0] req_addr [NUM_REQ] = '{32'h0000_0800, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  assign s_araddr = {req_addr[3], req_addr[2], req_addr[1], req_addr[0]};

  always #5 aclk = ~aclk;

  audio_mem_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_idx(grant_idx), .busy(busy)
  );

  typedef struct {
    logic [3:0]  arv;
    logic        mar;
    logic        mrv;
    logic [31:0] mrd;
    logic [3:0]  srr;
    logic [3:0]  e_ard;
    logic [3:0]  e_rv;
    logic        e_marv;
    logic        e_mrr;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [31:0] e_maddr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] act_out();
    return {19'd0, s_arready, s_rvalid, m_arvalid, m_rready, grant_idx, busy, m_araddr, s_rdata};
  endfunction

  function automatic logic [95:0] exp_out(input vec_t v);
    return {19'd0, v.e_ard, v.e_rv, v.e_marv, v.e_mrr, v.e_gnt, v.e_busy, v.e_maddr, v.e_rdata};
  endfunction

  task automatic add_row(input logic [3:0] arv, input logic mar, input logic mrv, input logic [31:0] mrd,
                         input logic [3:0] srr, input logic [3:0] e_ard, input logic [3:0] e_rv,
                         input logic e_marv, input logic e_mrr, input int e_gnt, input logic e_busy,
                         input logic [31:0] e_maddr, input logic [31:0] e_rdata);
    vec_t v;
    v = '{arv: arv, mar: mar, mrv: mrv, mrd: mrd, srr: srr, e_ard: e_ard, e_rv: e_rv,
          e_marv: e_marv, e_mrr: e_mrr, e_gnt: 2'(e_gnt), e_busy: e_busy,
          e_maddr: e_maddr, e_rdata: e_rdata};
    vecs.push_back(v);
  endtask

  // Four-cycle transaction for requester g: grant, address accept, data, response handshake.
  task automatic add_txn(input logic [3:0] arv_g, input logic [3:0] arv_rest, input int g,
                         input logic [31:0] data, input logic [31:0] prev);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    add_row(arv_g,    1'b1, 1'b0, 32'h0, 4'h0, oh,   4'h0, 1'b1, 1'b0, g, 1'b1, req_addr[g], prev);
    add_row(arv_rest, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, g, 1'b1, req_addr[g], prev);
    add_row(arv_rest, 1'b0, 1'b1, data,  4'h0, 4'h0, oh,   1'b0, 1'b0, g, 1'b1, req_addr[g], data);
    add_row(arv_rest, 1'b0, 1'b0, 32'h0, oh,   4'h0, 4'h0, 1'b0, 1'b0, g, 1'b0, req_addr[g], data);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int   exp_seq[$];
    int   grants[$];
    int   last_cyc;
    int   cnt0;
    int   idx;
    logic [31:0] held_addr;

    #1 aresetn = 1'b0;
    #11;
    chk("reset_state", act_out(), 96'd0);
    #10 aresetn = 1'b1;

    // Vector table.
    add_txn(4'b0010, 4'b0000, 1, 32'hDEAD_BEEF, 32'h0);
    add_row(4'b0000, 1'b0, 1'b1, 32'h1234_5678, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1, 1'b0, req_addr[1], 32'hDEAD_BEEF);
    add_row(4'b0000, 1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1, 1'b0, req_addr[1], 32'hDEAD_BEEF);
    add_txn(4'b0100, 4'b0000, 2, 32'h2222_0002, 32'hDEAD_BEEF);
`ifdef AUDIO_MEM_ARB_PRIO0_EN
    add_txn(4'b1001, 4'b1000, 0, 32'h3333_0000, 32'h2222_0002);
    add_txn(4'b1000, 4'b0000, 3, 32'h4444_0003, 32'h3333_0000);
`else
    add_txn(4'b1001, 4'b0001, 3, 32'h3333_0003, 32'h2222_0002);
    add_txn(4'b0001, 4'b0000, 0, 32'h4444_0000, 32'h3333_0003);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      s_arvalid = vecs[i].arv;
      m_arready = vecs[i].mar;
      m_rvalid  = vecs[i].mrv;
      m_rdata   = vecs[i].mrd;
      s_rready  = vecs[i].srr;
      tick();
      chk($sformatf("vec%0d", i), act_out(), exp_out(vecs[i]));
    end

    // Backpressure on every handshake for requester 2.
    s_arvalid = 4'b0100; m_arready = 1'b0; m_rvalid = 1'b0; s_rready = 4'b0000;
    tick();
    chk("bp_grant", {88'd0, s_arready, m_arvalid, 1'b0, grant_idx}, {88'd0, 4'b0100, 1'b1, 1'b0, 2'd2});
    held_addr = m_araddr;
    chk("bp_addr", {64'd0, m_araddr}, {64'd0, 32'h0000_2000});
    s_arvalid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_ar_hold%0d", c), {59'd0, m_arvalid, m_araddr, s_arready}, {59'd0, 1'b1, held_addr, 4'b0000});
    end
    m_arready = 1'b1;
    tick();
    chk("bp_ar_accept", {94'd0, m_arvalid, m_rready}, {94'd0, 1'b0, 1'b1});
    m_arready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      chk($sformatf("bp_r_wait%0d", c), {87'd0, m_rready, s_rvalid, s_arready}, {87'd0, 1'b1, 4'b0000, 4'b0000});
    end
    m_rvalid = 1'b1; m_rdata = 32'h5555_0002;
    tick();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    s_rready = 4'b1011;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_resp_hold%0d", c), {56'd0, s_rvalid, s_arready, s_rdata}, {56'd0, 4'b0100, 4'b0000, 32'h5555_0002});
      tick();
    end
    s_rready = 4'b0100;
    tick();
    chk("bp_done", {87'd0, busy, s_rvalid, s_arready}, {87'd0, 1'b0, 4'b0000, 4'b0000});
    s_rready = 4'b0000;

    // Asynchronous reset while waiting for read data.
    s_arvalid = 4'b0010; m_arready = 1'b1;
    tick();
    chk("rst_pre_grant", {94'd0, grant_idx}, {94'd0, 2'd1});
    s_arvalid = 4'b0000;
    tick();
    chk("rst_pre_data", {95'd0, m_rready}, {95'd0, 1'b1});
    #3 aresetn = 1'b0;
    #1;
    chk("async_reset", act_out(), 96'd0);
    @(posedge aclk);
    @(posedge aclk);
    #3 aresetn = 1'b1;
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick();
    chk("late_rvalid_ignored", act_out(), 96'd0);
    m_rvalid = 1'b0;

    // Continuous requesters with a memory that always answers at once.
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hA0A0_0000; s_rready = 4'b1111;
`ifdef AUDIO_MEM_ARB_PRIO0_EN
    exp_seq = '{0, 0, 0, 2, 3};
    s_arvalid = 4'b1101;
`else
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    s_arvalid = 4'b1111;
`endif
    last_cyc = 0;
    cnt0 = 0;
    for (int cyc = 0; cyc < 80 && grants.size() < exp_seq.size(); cyc++) begin
      tick();
      chk($sformatf("rvalid_onehot0_c%0d", cyc), {95'd0, $onehot0(s_rvalid)}, {95'd0, 1'b1});
      if (s_arready != 4'b0000) begin
        idx = 0;
        for (int b = 0; b < NUM_REQ; b++) if (s_arready[b]) idx = b;
        chk($sformatf("arready_onehot_g%0d", grants.size()), {95'd0, $onehot(s_arready)}, {95'd0, 1'b1});
        chk($sformatf("grant_idx_g%0d", grants.size()), {94'd0, grant_idx}, {94'd0, 2'(idx)});
        if (grants.size() > 0)
          chk($sformatf("issue_interval_g%0d", grants.size()), 96'(cyc - last_cyc), 96'd4);
        last_cyc = cyc;
        grants.push_back(idx);
`ifdef AUDIO_MEM_ARB_PRIO0_EN
        if (idx == 0) begin
          cnt0++;
          if (cnt0 == 3) s_arvalid[0] = 1'b0;
        end else begin
          s_arvalid[idx] = 1'b0;
        end
`endif
      end
    end
    chk("grant_count", 96'(grants.size()), 96'(exp_seq.size()));
    for (int k = 0; k < grants.size() && k < exp_seq.size(); k++)
      chk($sformatf("grant_order%0d", k), 96'(grants[k]), 96'(exp_seq[k]));
    s_arvalid = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
